// File: rtl/uart_param_if.sv
// Bus-side bundle of the uart_param block.
// master: register wrapper; slave: the UART.
interface uart_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_error;
  logic                 rx_frame_error;
  logic                 rx_break;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data,
    input  rx_parity_error,
    input  rx_frame_error,
    input  rx_break
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data,
    output rx_parity_error,
    output rx_frame_error,
    output rx_break
  );
endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: clk/rst, baud_div, rx/tx pins,
// status is_receiving/is_transmitting, bus = tx/rx handshake.
module uart_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 rx,
  output logic                 tx,
  output logic                 is_receiving,
  output logic                 is_transmitting,
  uart_param_if.slave          bus
);

  localparam int M   = OVERSAMPLE / 2;
  localparam int TCW = $clog2(STOP_BITS * OVERSAMPLE + 1);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] T_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] T_PRE  = TCW'(M - 1);
  localparam logic [TCW-1:0] T_MID  = TCW'(M);
  localparam logic [TCW-1:0] T_DEC  = TCW'(M + 1);
  localparam logic [TCW-1:0] T_STOP =
    TCW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 2);

  // ---------------- tick generator ----------------
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tick;

  assign tick  = (div_q == '0);
  assign div_d = tick ? baud_div : div_q - DIV_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst) div_q <= baud_div;
    else      div_q <= div_d;
  end

  // ---------------- rx synchroniser ----------------
  logic sync1_q, rxs_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK
  } rx_st_e;

  rx_st_e               rx_st_q, rx_st_d;
  logic [TCW-1:0]       rx_tc_q, rx_tc_d, rx_tcn;
  logic [1:0]           rx_vt_q, rx_vt_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [BCW-1:0]       rx_bc_q, rx_bc_d;
  logic                 rx_pb_q, rx_pb_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_brk_q, rx_brk_d;
  logic                 rx_maj, rx_exp, rx_zero;

  // rx_tc counts ticks since start detection, modulo OVERSAMPLE
  assign rx_tcn = (rx_tc_q == T_LAST) ? '0 : rx_tc_q + TCW'(1);
  // two earlier votes plus the live sample at the decision tick
  assign rx_maj = (rx_vt_q[0] & rx_vt_q[1]) |
                  (rx_vt_q[0] & rxs_q) |
                  (rx_vt_q[1] & rxs_q);
  assign rx_exp  = PAR_ODD ? ~^rx_sh_q : ^rx_sh_q;
  assign rx_zero = (rx_sh_q == '0) && !(PAR_EN && rx_pb_q);

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_tc_d    = rx_tc_q;
    rx_vt_d    = rx_vt_q;
    rx_sh_d    = rx_sh_q;
    rx_bc_d    = rx_bc_q;
    rx_pb_d    = rx_pb_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_brk_d   = rx_brk_q;
    rx_valid_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (tick && !rxs_q) begin
          rx_st_d = RX_START;
          rx_tc_d = '0;
        end
      end
      RX_BRK: begin
        if (tick && rxs_q) rx_st_d = RX_IDLE;
      end
      default: begin
        if (tick) begin
          rx_tc_d = rx_tcn;
          if (rx_tcn == T_PRE) rx_vt_d[0] = rxs_q;
          if (rx_tcn == T_MID) rx_vt_d[1] = rxs_q;
          if (rx_tcn == T_DEC) begin
            case (rx_st_q)
              RX_START: begin
                rx_bc_d = '0;
                rx_st_d = rx_maj ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_sh_d = {rx_maj, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bc_q == B_LAST)
                  rx_st_d = PAR_EN ? RX_PAR : RX_STOP;
                else
                  rx_bc_d = rx_bc_q + BCW'(1);
              end
              RX_PAR: begin
                rx_pb_d = rx_maj;
                rx_st_d = RX_STOP;
              end
              RX_STOP: begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q;
                rx_perr_d  = PAR_EN && (rx_pb_q != rx_exp);
                rx_ferr_d  = !rx_maj;
                rx_brk_d   = !rx_maj && rx_zero;
                rx_st_d    = rx_brk_d ? RX_BRK : RX_IDLE;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st_q    <= RX_IDLE;
      rx_tc_q    <= '0;
      rx_vt_q    <= 2'b11;
      rx_sh_q    <= '0;
      rx_bc_q    <= '0;
      rx_pb_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_tc_q    <= rx_tc_d;
      rx_vt_q    <= rx_vt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bc_q    <= rx_bc_d;
      rx_pb_q    <= rx_pb_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_brk_q   <= rx_brk_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_ALIGN, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_st_e;

  tx_st_e               tx_st_q, tx_st_d;
  logic [TCW-1:0]       tx_tc_q, tx_tc_d;
  logic [BCW-1:0]       tx_bc_q, tx_bc_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_tc_q == T_LAST);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tc_d  = tx_tc_q;
    tx_bc_d  = tx_bc_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    tx_d     = tx_q;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_sh_d  = bus.tx_data;
          tx_par_d = PAR_ODD ? ~^bus.tx_data : ^bus.tx_data;
          tx_st_d  = TX_ALIGN;
        end
      end
      TX_ALIGN: begin
        // start bit edge lands on the tick grid
        if (tick) begin
          tx_d    = 1'b0;
          tx_tc_d = '0;
          tx_st_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + TCW'(1);
          if (tx_bit_end) begin
            tx_tc_d = '0;
            tx_bc_d = '0;
            tx_d    = tx_sh_q[0];
            tx_st_d = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + TCW'(1);
          if (tx_bit_end) begin
            tx_tc_d = '0;
            if (tx_bc_q == B_LAST) begin
              tx_st_d = PAR_EN ? TX_PAR : TX_STOP;
              tx_d    = PAR_EN ? tx_par_q : 1'b1;
            end else begin
              tx_bc_d = tx_bc_q + BCW'(1);
              tx_sh_d = tx_sh_q >> 1;
              tx_d    = tx_sh_q[1];
            end
          end
        end
      end
      TX_PAR: begin
        if (tick) begin
          tx_tc_d = tx_tc_q + TCW'(1);
          if (tx_bit_end) begin
            tx_tc_d = '0;
            tx_d    = 1'b1;
            tx_st_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        // all stop bits timed as one long high period
        if (tick) begin
          tx_tc_d = tx_tc_q + TCW'(1);
          if (tx_tc_q == T_STOP) tx_st_d = TX_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st_q  <= TX_IDLE;
      tx_tc_q  <= '0;
      tx_bc_q  <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_tc_q  <= tx_tc_d;
      tx_bc_q  <= tx_bc_d;
      tx_sh_q  <= tx_sh_d;
      tx_par_q <= tx_par_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------- outputs ----------------
  assign tx                  = tx_q;
  assign is_transmitting     = (tx_st_q != TX_IDLE);
  assign is_receiving        = (rx_st_q != RX_IDLE);
  assign bus.tx_ready        = (tx_st_q == TX_IDLE);
  assign bus.rx_valid        = rx_valid_q;
  assign bus.rx_data         = rx_data_q;
  assign bus.rx_parity_error = rx_perr_q;
  assign bus.rx_frame_error  = rx_ferr_q;
  assign bus.rx_break        = rx_brk_q;

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: 8N1 instance (a)
// and 8E1 instance (b), bit time 64 clk.
module tb_uart_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_drv, sel_b, loop_a, loop_b;
  logic        tx_a, tx_b, rx_a, rx_b;
  logic        recv_a, recv_b, xmit_a, xmit_b;

  always #5 clk = ~clk;

  uart_param_if #(.DATA_BITS(8)) bus_a ();
  uart_param_if #(.DATA_BITS(8)) bus_b ();

  assign rx_a = loop_a ? tx_a : (sel_b ? 1'b1 : rx_drv);
  assign rx_b = loop_b ? tx_b : (sel_b ? rx_drv : 1'b1);

  uart_param #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .OVERSAMPLE(16), .DIV_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .rx(rx_a), .tx(tx_a),
    .is_receiving(recv_a), .is_transmitting(xmit_a),
    .bus(bus_a)
  );

  uart_param #(
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .OVERSAMPLE(16), .DIV_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .rx(rx_b), .tx(tx_b),
    .is_receiving(recv_b), .is_transmitting(xmit_b),
    .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  int         cnt_a = 0, cnt_b = 0;
  logic [7:0] qa[$];
  logic [7:0] da = '0, db = '0;
  logic       pa = 0, fa = 0, ba = 0;
  logic       pb = 0, fb = 0, bb = 0;

  always @(negedge clk) begin
    if (bus_a.rx_valid) begin
      cnt_a++;
      qa.push_back(bus_a.rx_data);
      da = bus_a.rx_data;
      pa = bus_a.rx_parity_error;
      fa = bus_a.rx_frame_error;
      ba = bus_a.rx_break;
    end
    if (bus_b.rx_valid) begin
      cnt_b++;
      db = bus_b.rx_data;
      pb = bus_b.rx_parity_error;
      fb = bus_b.rx_frame_error;
      bb = bus_b.rx_break;
    end
  end

  task automatic send_rx(input logic [15:0] v, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_drv = v[i];
      repeat (64) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1) begin
      errors++; $display("FAIL rst_tx got %b want 1", tx_a);
    end
    checks++;
    if (bus_a.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", bus_a.tx_ready);
    end
    checks++;
    if (bus_a.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", bus_a.rx_valid);
    end
    checks++;
    if (bus_a.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h want 00", bus_a.rx_data);
    end
    checks++;
    if ({bus_a.rx_parity_error, bus_a.rx_frame_error,
         bus_a.rx_break} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got nonzero want 000");
    end
    checks++;
    if ({recv_a, xmit_a, recv_b, xmit_b} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_busy got %b%b%b%b want 0000",
               recv_a, xmit_a, recv_b, xmit_b);
    end
    checks++;
    if (tx_b !== 1'b1) begin
      errors++; $display("FAIL rst_tx_b got %b want 1", tx_b);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback;
    int base, fr, bt, n;
    loop_a = 1'b1;
    base = cnt_a;
    bus_a.tx_data  = 8'hA5;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    checks++;
    if (bus_a.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL lb_ready_fall got %b want 0", bus_a.tx_ready);
    end
    for (n = 0; n < 100 && tx_a; n++) @(negedge clk);
    checks++;
    if (tx_a !== 1'b0) begin
      errors++; $display("FAIL lb_start timeout got tx=1 want 0");
    end
    fr = 0;
    bt = 0;
    while (!bus_a.tx_ready && fr < 2000) begin
      @(negedge clk);
      fr++;
      if (bt == 0 && tx_a) bt = fr;
    end
    checks++;
    if (bt != 64) begin
      errors++; $display("FAIL lb_bit_time got %0d want 64", bt);
    end
    checks++;
    if (fr != 640) begin
      errors++; $display("FAIL lb_frame got %0d want 640", fr);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_a - base != 1) begin
      errors++;
      $display("FAIL lb_count got %0d want 1", cnt_a - base);
    end
    checks++;
    if (da !== 8'hA5 || {pa, fa, ba} !== 3'b000) begin
      errors++;
      $display("FAIL lb_data got %h/%b%b%b want a5/000",
               da, pa, fa, ba);
    end
    loop_a = 1'b0;
  endtask

  task automatic test_parity;
    int base, n;
    loop_b = 1'b1;
    base = cnt_b;
    bus_b.tx_data  = 8'h07;
    bus_b.tx_valid = 1'b1;
    @(negedge clk);
    bus_b.tx_valid = 1'b0;
    for (n = 0; n < 100 && tx_b; n++) @(negedge clk);
    repeat (9 * 64 + 32) @(negedge clk);
    checks++;
    if (tx_b !== 1'b1) begin
      errors++; $display("FAIL par_tx_bit got %b want 1", tx_b);
    end
    for (n = 0; n < 2000 && !bus_b.tx_ready; n++) @(negedge clk);
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_b - base != 1 || db !== 8'h07 || pb !== 1'b0) begin
      errors++;
      $display("FAIL par_loop got n=%0d %h p=%b want 1 07 0",
               cnt_b - base, db, pb);
    end
    loop_b = 1'b0;
    sel_b  = 1'b1;
    rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    send_rx({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_b - base != 2) begin
      errors++;
      $display("FAIL par_bad_count got %0d want 2", cnt_b - base);
    end
    checks++;
    if (db !== 8'h07 || pb !== 1'b1 || fb !== 1'b0) begin
      errors++;
      $display("FAIL par_bad got %h p=%b f=%b want 07 1 0",
               db, pb, fb);
    end
    sel_b = 1'b0;
  endtask

  task automatic test_glitch;
    int base;
    base = cnt_a;
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (recv_a !== 1'b1) begin
      errors++; $display("FAIL gl_busy got %b want 1", recv_a);
    end
    repeat (8) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (recv_a !== 1'b0 || cnt_a != base) begin
      errors++;
      $display("FAIL gl_reject got busy=%b n=%0d want 0 0",
               recv_a, cnt_a - base);
    end
  endtask

  task automatic test_frame_break;
    int base;
    base = cnt_a;
    send_rx({7'b0, 8'h55, 1'b0}, 10);
    repeat (200) @(negedge clk);
    checks++;
    if (cnt_a - base != 1 || da !== 8'h55) begin
      errors++;
      $display("FAIL fe_frame got n=%0d %h want 1 55",
               cnt_a - base, da);
    end
    checks++;
    if (fa !== 1'b1 || ba !== 1'b0) begin
      errors++;
      $display("FAIL fe_flags got f=%b b=%b want 1 0", fa, ba);
    end
    base = cnt_a;
    rx_drv = 1'b0;
    repeat (1920) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (cnt_a - base != 1 || da !== 8'h00) begin
      errors++;
      $display("FAIL brk_frame got n=%0d %h want 1 00",
               cnt_a - base, da);
    end
    checks++;
    if (fa !== 1'b1 || ba !== 1'b1 || recv_a !== 1'b0) begin
      errors++;
      $display("FAIL brk_flags got f=%b b=%b busy=%b want 1 1 0",
               fa, ba, recv_a);
    end
    send_rx({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_a - base != 2 || da !== 8'h3C ||
        {pa, fa, ba} !== 3'b000) begin
      errors++;
      $display("FAIL brk_after got n=%0d %h/%b%b%b want 2 3c/000",
               cnt_a - base, da, pa, fa, ba);
    end
  endtask

  task automatic test_back_to_back;
    int base, qs, n, gap, rdy;
    loop_a = 1'b1;
    base = cnt_a;
    qs = qa.size();
    bus_a.tx_data  = 8'h01;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_data = 8'h02;
    for (n = 0; n < 2000 && !bus_a.tx_ready; n++)
      @(negedge clk);
    checks++;
    if (bus_a.tx_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end timeout got 0 want 1");
    end
    gap = 0;
    rdy = 0;
    while (tx_a && gap < 100) begin
      if (bus_a.tx_ready) rdy++;
      gap++;
      @(negedge clk);
    end
    bus_a.tx_valid = 1'b0;
    checks++;
    if (gap > 4 || gap < 1) begin
      errors++; $display("FAIL b2b_gap got %0d want 1..4", gap);
    end
    checks++;
    if (rdy != 1) begin
      errors++; $display("FAIL b2b_ready got %0d want 1", rdy);
    end
    for (n = 0; n < 2000 && !bus_a.tx_ready; n++)
      @(negedge clk);
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_a - base != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", cnt_a - base);
    end else begin
      checks++;
      if (qa[qs] !== 8'h01 || qa[qs+1] !== 8'h02) begin
        errors++;
        $display("FAIL b2b_data got %h %h want 01 02",
                 qa[qs], qa[qs+1]);
      end
    end
    loop_a = 1'b0;
  endtask

  task automatic test_reset_mid;
    int base;
    base = cnt_a;
    bus_a.tx_data  = 8'h00;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    send_rx({12'b0, 4'b1010}, 4);
    checks++;
    if (recv_a !== 1'b1 || xmit_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got rx=%b tx=%b want 1 1",
               recv_a, xmit_a);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || bus_a.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_tx got tx=%b rdy=%b want 1 1",
               tx_a, bus_a.tx_ready);
    end
    checks++;
    if (recv_a !== 1'b0 || xmit_a !== 1'b0 ||
        bus_a.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_state got rx=%b tx=%b d=%h want 0 0 00",
               recv_a, xmit_a, bus_a.rx_data);
    end
    rst = 1'b1;
    repeat (800) @(negedge clk);
    checks++;
    if (cnt_a != base) begin
      errors++;
      $display("FAIL mid_drop got %0d want 0", cnt_a - base);
    end
    send_rx({6'b0, 1'b1, 8'h96, 1'b0}, 10);
    repeat (100) @(negedge clk);
    checks++;
    if (cnt_a - base != 1 || da !== 8'h96 ||
        {pa, fa, ba} !== 3'b000) begin
      errors++;
      $display("FAIL mid_next got n=%0d %h/%b%b%b want 1 96/000",
               cnt_a - base, da, pa, fa, ba);
    end
  endtask

  initial begin
    rst            = 1'b0;
    baud_div       = 16'd3;
    rx_drv         = 1'b1;
    sel_b          = 1'b0;
    loop_a         = 1'b0;
    loop_b         = 1'b0;
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = '0;
    bus_b.tx_valid = 1'b0;
    bus_b.tx_data  = '0;
    @(negedge clk);
    test_reset;
    test_loopback;
    test_parity;
    test_glitch;
    test_frame_break;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
